// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the ALU.
// Priority per edge: flush > stall > load; forwarding is combinational on the stored indices.
module id_ex_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_val,
    input  logic [XLEN-1:0] id_rs2_val,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_a_sel,
    input  logic            id_b_sel,
    input  logic [3:0]      id_alu_ctrl,
    input  logic            id_reg_write,
    input  logic            mem_reg_write,
    input  logic [REGW-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_reg_write,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_valid
);

    logic            valid_q,     valid_d;
    logic            reg_write_q, reg_write_d;
    logic [3:0]      alu_ctrl_q,  alu_ctrl_d;
    logic [XLEN-1:0] pc_q,        pc_d;
    logic [XLEN-1:0] rs1_val_q,   rs1_val_d;
    logic [XLEN-1:0] rs2_val_q,   rs2_val_d;
    logic [XLEN-1:0] imm_q,       imm_d;
    logic [REGW-1:0] rs1_q,       rs1_d;
    logic [REGW-1:0] rs2_q,       rs2_d;
    logic [REGW-1:0] rd_q,        rd_d;
    logic            a_sel_q,     a_sel_d;
    logic            b_sel_q,     b_sel_d;

    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;

    // MEM is the younger producer, so it beats WB; x0 is never forwarded
    always_comb begin
        fwd1 = rs1_val_q;
        if (mem_reg_write && (mem_rd == rs1_q) && (rs1_q != '0)) begin
            fwd1 = mem_result;
        end else if (wb_reg_write && (wb_rd == rs1_q) && (rs1_q != '0)) begin
            fwd1 = wb_result;
        end
    end

    always_comb begin
        fwd2 = rs2_val_q;
        if (mem_reg_write && (mem_rd == rs2_q) && (rs2_q != '0)) begin
            fwd2 = mem_result;
        end else if (wb_reg_write && (wb_rd == rs2_q) && (rs2_q != '0)) begin
            fwd2 = wb_result;
        end
    end

    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        alu_ctrl_d  = alu_ctrl_q;
        pc_d        = pc_q;
        rs1_val_d   = rs1_val_q;
        rs2_val_d   = rs2_val_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        a_sel_d     = a_sel_q;
        b_sel_d     = b_sel_q;
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            alu_ctrl_d  = '0;
        end else if (stall) begin
            // Capture forwarded operands so a WB value survives WB retiring
            rs1_val_d = fwd1;
            rs2_val_d = fwd2;
        end else begin
            valid_d     = id_valid;
            reg_write_d = id_reg_write & id_valid;
            alu_ctrl_d  = id_alu_ctrl;
            pc_d        = id_pc;
            rs1_val_d   = id_rs1_val;
            rs2_val_d   = id_rs2_val;
            imm_d       = id_imm;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
            a_sel_d     = id_a_sel;
            b_sel_d     = id_b_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            alu_ctrl_q  <= '0;
            pc_q        <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            a_sel_q     <= 1'b0;
            b_sel_q     <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            alu_ctrl_q  <= alu_ctrl_d;
            pc_q        <= pc_d;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            a_sel_q     <= a_sel_d;
            b_sel_q     <= b_sel_d;
        end
    end

    assign alu_a        = a_sel_q ? pc_q : fwd1;
    assign alu_b        = b_sel_q ? imm_q : fwd2;
    assign alu_ctrl     = alu_ctrl_q;
    assign ex_rs2_data  = fwd2;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q & valid_q;
    assign ex_valid     = valid_q;

endmodule
